// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and helpers for the reg_file_sb slice.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   SP_IDX_DEF / SP_INIT_DEF: stack-pointer register index and its reset value
//   rd_off()                : bit offset of read port k inside a flattened bus
package reg_file_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int SP_IDX_DEF  = 29;
  localparam int SP_INIT_DEF = 128;

  // Port k of a flattened per-port bus sits at [rd_off(k, w) +: w].
  function automatic int rd_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits plus a registered popcount.
//   clk_i, rst_i          : clock, async active-high reset
//   wr_en_i, wr_addr_i    : write-back clears pend[wr_addr_i]
//   iss_en_i, iss_addr_i  : issue sets pend[iss_addr_i] (wins over a same-address clear)
//   pend_o                : current pending vector, bit per register
//   pend_cnt_o            : number of pending registers, updated on the same edge
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic                iss_en_i,
  input  logic [ADDR_W-1:0]   iss_addr_i,
  output logic [2**ADDR_W-1:0] pend_o,
  output logic [ADDR_W:0]     pend_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  always_comb begin
    pend_nxt = pend_o;
    if (wr_en_i)  pend_nxt[wr_addr_i]  = 1'b0;
    // Issue applied after the clear: a new producer for the same register wins.
    if (iss_en_i) pend_nxt[iss_addr_i] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  // Count from the next-state vector so the count can never drift from the bits.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_o     <= '0;
      pend_cnt_o <= '0;
    end else begin
      pend_o     <= pend_nxt;
      pend_cnt_o <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with integrated scoreboard.
//   clk_i, rst_i            : clock, async active-high reset
//   rd_vld_i   [NUM_RD]     : read port k in use (affects stall_o only)
//   rd_addr_i  [NUM_RD*ADDR_W], rd_data_o [NUM_RD*DATA_W] : combinational reads
//   rd_busy_o  [NUM_RD]     : pending bit of each port's addressed register
//   stall_o                 : some in-use port reads a pending register
//   wr_en_i, wr_addr_i, wr_data_i : write-back (clears pending)
//   iss_en_i, iss_addr_i    : issue (sets pending)
//   pend_cnt_o              : registered count of pending registers
// Build option: define REG_FILE_BYPASS_EN to forward the write-back value and
// mask busy on a same-cycle read of the register being written.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int SP_IDX   = SP_IDX_DEF,
  parameter int SP_INIT  = SP_INIT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD-1:0]        rd_vld_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic                     stall_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic [ADDR_W:0]          pend_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pend;
  logic                         wr_ok;

  assign wr_ok = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));

  // Only the addressed register is touched; no self-rewrite of the rest.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs         <= '0;
      regs[SP_IDX] <= DATA_W'(SP_INIT);
    end else if (wr_ok) begin
      regs[wr_addr_i] <= wr_data_i;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .pend_o     (pend),
    .pend_cnt_o (pend_cnt_o)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;

    assign addr    = rd_addr_i[rd_off(k, ADDR_W) +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

`ifdef REG_FILE_BYPASS_EN
    logic byp;
    // Forwarding also hides a same-cycle issue; busy shows up next cycle.
    assign byp = wr_ok && (addr == wr_addr_i);
    assign rd_data_o[rd_off(k, DATA_W) +: DATA_W] =
      is_zero ? '0 : (byp ? wr_data_i : regs[addr]);
    assign rd_busy_o[k] = !is_zero && !byp && pend[addr];
`else
    assign rd_data_o[rd_off(k, DATA_W) +: DATA_W] = is_zero ? '0 : regs[addr];
    assign rd_busy_o[k] = !is_zero && pend[addr];
`endif
  end

  assign stall_o = |(rd_vld_i & rd_busy_o);

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  rd_vld_i = '0;
  logic [9:0]  rd_addr_i = '0;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic        stall_o;
  logic        wr_en_i = 1'b0;
  logic [4:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        iss_en_i = 1'b0;
  logic [4:0]  iss_addr_i = '0;
  logic [5:0]  pend_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  reg_file_sb dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_vld_i   (rd_vld_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .stall_o    (stall_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .pend_cnt_o (pend_cnt_o)
  );

  // Inputs applied for one cycle; expected outputs are those seen before the edge.
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [1:0]  vld;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        stall;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                              logic ie, logic [4:0] ia, logic [1:0] vld,
                              logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] d0, logic [31:0] d1,
                              logic [1:0] busy, logic stall, logic [5:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.vld = vld;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.busy = busy;
    v.stall = stall; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic [1:0] vld,
                       input logic [4:0] a0, input logic [4:0] a1);
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    iss_en_i = ie; iss_addr_i = ia;
    rd_vld_i = vld; rd_addr_i = {a1, a0};
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] busy, input logic stall, input logic [5:0] cnt);
    chk({nm, ".d0"},    rd_data_o[31:0],  d0);
    chk({nm, ".d1"},    rd_data_o[63:32], d1);
    chk({nm, ".busy"},  32'(rd_busy_o),   32'(busy));
    chk({nm, ".stall"}, 32'(stall_o),     32'(stall));
    chk({nm, ".cnt"},   32'(pend_cnt_o),  32'(cnt));
  endtask

  initial begin
    // Reset pulse between clock edges; outputs must reflect it with no clock.
    #2 rst_i = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd29, 5'd5);
    #1 chk_rd("reset", 32'd128, 32'd0, 2'b00, 1'b0, 6'd0);
    rst_i = 1'b0;

    tv[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 2'b00, 29, 5,  32'd128,       32'd0,         2'b00, 0, 0);
    tv[1]  = mk(1, 0, 32'h1,        0, 0, 2'b00, 7,  0,  32'hDEADBEEF,  32'd0,         2'b00, 0, 0);
    tv[2]  = mk(0, 0, 32'h0,        1, 3, 2'b00, 0,  0,  32'd0,         32'd0,         2'b00, 0, 0);
    tv[3]  = mk(0, 0, 32'h0,        0, 0, 2'b10, 7,  3,  32'hDEADBEEF,  32'd0,         2'b10, 1, 1);
    tv[4]  = mk(1, 3, 32'h33,       0, 0, 2'b00, 7,  7,  32'hDEADBEEF,  32'hDEADBEEF,  2'b00, 0, 1);
    tv[5]  = mk(0, 0, 32'h0,        0, 0, 2'b10, 0,  3,  32'd0,         32'h33,        2'b00, 0, 0);
    tv[6]  = mk(0, 0, 32'h0,        1, 4, 2'b00, 4,  3,  32'd0,         32'h33,        2'b00, 0, 0);
    tv[7]  = mk(1, 4, 32'h55,       1, 4, 2'b11, 3,  7,  32'h33,        32'hDEADBEEF,  2'b00, 0, 1);
    tv[8]  = mk(0, 0, 32'h0,        1, 4, 2'b01, 4,  0,  32'h55,        32'd0,         2'b01, 1, 1);
    tv[9]  = mk(0, 0, 32'h0,        0, 0, 2'b11, 4,  29, 32'h55,        32'd128,       2'b01, 1, 1);
    tv[10] = mk(1, 4, 32'h66,       1, 5, 2'b00, 5,  7,  32'd0,         32'hDEADBEEF,  2'b00, 0, 1);
    tv[11] = mk(0, 0, 32'h0,        0, 0, 2'b11, 4,  5,  32'h66,        32'd0,         2'b10, 1, 1);
    tv[12] = mk(1, 8, 32'h88,       0, 0, 2'b00, 5,  4,  32'd0,         32'h66,        2'b01, 0, 1);
    tv[13] = mk(0, 0, 32'h0,        0, 0, 2'b01, 8,  5,  32'h88,        32'd0,         2'b10, 0, 1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].ie, tv[i].ia, tv[i].vld, tv[i].a0, tv[i].a1);
      #1 chk_rd($sformatf("vec%0d", i), tv[i].d0, tv[i].d1, tv[i].busy, tv[i].stall, tv[i].cnt);
    end

    // Same-cycle read of the register being written (9 is pending first).
    @(negedge clk_i);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 2'b00, 5'd0, 5'd0);
    @(negedge clk_i);
    drive(1'b1, 5'd9, 32'hA5A5, 1'b0, 5'd0, 2'b01, 5'd9, 5'd0);
`ifdef REG_FILE_BYPASS_EN
    #1 chk_rd("bypass", 32'hA5A5, 32'd0, 2'b00, 1'b0, 6'd2);
`else
    #1 chk_rd("nobypass", 32'd0, 32'd0, 2'b01, 1'b1, 6'd2);
`endif
    @(negedge clk_i);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b01, 5'd9, 5'd0);
    #1 chk_rd("after_wr9", 32'hA5A5, 32'd0, 2'b00, 1'b0, 6'd1);

    // Issue every address (0 is dropped, 5 already pending).
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 2'b00, 5'd0, 5'd0);
    end
    @(negedge clk_i);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd0, 5'd31);
    #1 chk_rd("full", 32'd0, 32'd0, 2'b10, 1'b1, 6'd31);

    // Reset mid-cycle clears everything immediately.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd7, 5'd29);
    #1 rst_i = 1'b1;
    #1 chk_rd("midrst", 32'd0, 32'd128, 2'b00, 1'b0, 6'd0);
    rd_addr_i = {5'd31, 5'd1};
    #1 chk("midrst.busy", 32'(rd_busy_o), 32'd0);
    rst_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
